// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional auto-repeat is enabled in keypad_scan by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [COLS-1:0] COL_IDLE = 4'b1110;

  // Rows are active-low; the lowest-index low row wins when several are down.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) idx = 2'(r);
    end
    return idx;
  endfunction

  function automatic logic [COLS-1:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

  function automatic key_code_t make_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Key-event handshake between the scanner (master) and the input-handling logic (slave).
interface keypad_if;
  import keypad_pkg::*;

  key_code_t key_code;
  logic      key_valid;
  logic      key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer with asynchronous reset to a configurable value.
module sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner/debouncer paced by scan_tick; delivers key codes over keypad_if.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS     = 4,
  parameter int REPEAT_DELAY_TICKS = 100,
  parameter int REPEAT_RATE_TICKS  = 20
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            scan_tick,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  keypad_if.master        key_bus,
  output logic            key_held,
  output logic            overrun
);

  localparam int MAX_RPT  = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                     : REPEAT_RATE_TICKS;
  localparam int MAX_TICK = (DEBOUNCE_TICKS > MAX_RPT) ? DEBOUNCE_TICKS : MAX_RPT;
  localparam int CNT_W    = $clog2(MAX_TICK) + 1;

  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_TICKS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  logic [ROWS-1:0] rs;

  sync2 #(
    .WIDTH   (ROWS),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (row_in),
    .q      (rs)
  );

  state_e          state_d, state_q;
  logic [1:0]      col_d, col_q;
  logic [1:0]      lat_row_d, lat_row_q;
  logic [1:0]      lat_col_d, lat_col_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  key_code_t       key_code_d, key_code_q;
  logic            key_valid_d, key_valid_q;
  logic            key_held_d, key_held_q;
  logic            overrun_d, overrun_q;
  logic [COLS-1:0] col_out_d, col_out_q;
  logic            row_low;
  logic            emit;
  logic [CNT_W-1:0] cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY_TICKS);
  localparam logic [CNT_W-1:0] RPT_RATE  = CNT_W'(REPEAT_RATE_TICKS);

  logic [CNT_W-1:0] rpt_d, rpt_q;
  logic [CNT_W-1:0] rpt_inc;
  logic             rpt_first_d, rpt_first_q;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_held_d  = key_held_q;
    overrun_d   = 1'b0;
    emit        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    rpt_inc     = sat_inc(rpt_q);
`endif
    row_low = ~rs[lat_row_q];
    cnt_inc = sat_inc(cnt_q);

    if (key_valid_q && key_bus.key_ready) key_valid_d = 1'b0;

    if (scan_tick) begin
      case (state_q)
        ST_SCAN: begin
          if (rs != 4'b1111) begin
            lat_col_d = col_q;
            lat_row_d = lowest_low_row(rs);
            cnt_d     = CNT_ONE;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LIMIT) begin
              emit       = 1'b1;
              key_held_d = 1'b1;
              state_d    = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              rpt_d       = '0;
              rpt_first_d = 1'b0;
`endif
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!row_low) begin
            cnt_d   = CNT_ONE;
            state_d = ST_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          // First repeat waits the long delay, later ones the short rate.
          else if (rpt_inc >= (rpt_first_q ? RPT_RATE : RPT_DELAY)) begin
            emit        = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b1;
          end else begin
            rpt_d = rpt_inc;
          end
`endif
        end
        ST_RELEASE: begin
          if (!row_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LIMIT) begin
              key_held_d = 1'b0;
              state_d    = ST_SCAN;
              col_d      = col_q + 2'd1;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    // An unaccepted pending code is kept; the new event is dropped instead.
    if (emit) begin
      if (!key_valid_q || key_bus.key_ready) begin
        key_code_d  = make_code(lat_row_q, lat_col_q);
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    col_out_d = col_drive(col_d);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
      col_out_q   <= COL_IDLE;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
      col_out_q   <= col_out_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign col_out           = col_out_q;
  assign key_bus.key_code  = key_code_q;
  assign key_bus.key_valid = key_valid_q;
  assign key_held          = key_held_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a matrix keypad model drives rows from col_out.
module tb_keypad_scan;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_DELAY = 8;
  localparam int RPT_RATE  = 3;
`else
  localparam int RPT_DELAY = 100;
  localparam int RPT_RATE  = 20;
`endif

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       scan_tick = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_held;
  logic       overrun;
  logic [15:0] pressed = '0;
  logic [3:0]  row_force = '0;
  int          tick_no = 0;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int evt_tick_q[$];
  int ovr_cnt = 0;

  keypad_if key_bus ();

  keypad_scan #(
    .DEBOUNCE_TICKS     (4),
    .REPEAT_DELAY_TICKS (RPT_DELAY),
    .REPEAT_RATE_TICKS  (RPT_RATE)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .scan_tick (scan_tick),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_bus   (key_bus),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
    row_in = row_in & ~row_force;
  end

  initial begin
    forever begin
      repeat (9) @(posedge clk_in);
      #1 scan_tick = 1'b1;
      @(posedge clk_in);
      #1 scan_tick = 1'b0;
    end
  end

  always @(posedge clk_in) if (scan_tick) tick_no <= tick_no + 1;

  // Monitor: every accepted key event is popped from the scoreboard and compared.
  always @(negedge clk_in) begin
    if (!rst && key_bus.key_valid && key_bus.key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got key_code=%0d, required no event", key_bus.key_code);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(key_bus.key_code) != e) begin
          failures++;
          $display("FAIL event_code: got %0d, required %0d", key_bus.key_code, e);
        end
      end
      evt_tick_q.push_back(tick_no);
    end
    if (!rst && overrun) ovr_cnt++;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk_in);
      while (!scan_tick) @(negedge clk_in);
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_held(input logic val, input int max_ticks, input string name);
    int t;
    t = 0;
    while (key_held !== val && t < max_ticks) begin
      wait_ticks(1);
      t++;
    end
    check(name, int'(key_held), int'(val));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_out"}, int'(col_out), 4'b1110);
    check({tag, "_key_code"}, int'(key_bus.key_code), 0);
    check({tag, "_key_valid"}, int'(key_bus.key_valid), 0);
    check({tag, "_key_held"}, int'(key_held), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    key_bus.key_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // First tick with no key advances column 0 -> 1.
    wait_ticks(1);
    check("scan_advance", int'(col_out), 4'b1101);

    // Row 2 / column 1 held for a while: exactly one event, code 9.
    exp_q.push_back(9);
    pressed[9] = 1'b1;
    wait_held(1'b1, 12, "press9_held_rise");
    check("press9_valid_with_held", int'(key_bus.key_valid), 1);
    check("press9_code", int'(key_bus.key_code), 9);
    wait_ticks(5);
    check("press9_still_held", int'(key_held), 1);
    pressed = '0;
    wait_ticks(3);
    check("release_3_ticks", int'(key_held), 1);
    wait_ticks(1);
    check("release_4_ticks", int'(key_held), 0);

    // Rows 0 and 3 both down on column 2: lowest row wins -> code 2.
    exp_q.push_back(2);
    pressed[2]  = 1'b1;
    pressed[14] = 1'b1;
    wait_held(1'b1, 12, "press2_held_rise");
    wait_ticks(2);
    pressed = '0;
    wait_held(1'b0, 8, "press2_released");

    // Bounce: row 1 low for two samples only, then scanning resumes.
    row_force = 4'b0010;
    wait_ticks(1);
    exp_col = col_out;
    wait_ticks(1);
    check("bounce_col_frozen", int'(col_out), int'(exp_col));
    row_force = '0;
    for (int i = 0; i < 3; i++) begin
      wait_ticks(1);
      exp_col = {exp_col[2:0], exp_col[3]};
      check("bounce_scan_resume", int'(col_out), int'(exp_col));
    end
    check("bounce_no_held", int'(key_held), 0);

    // Consumer stalled: code 5 stays pending, code 6 is dropped with one overrun.
    key_bus.key_ready = 1'b0;
    exp_q.push_back(5);
    pressed[5] = 1'b1;
    wait_held(1'b1, 12, "press5_held_rise");
    wait_ticks(1);
    pressed = '0;
    wait_held(1'b0, 8, "press5_released");
    pressed[6] = 1'b1;
    wait_held(1'b1, 12, "press6_held_rise");
    wait_ticks(1);
    pressed = '0;
    wait_held(1'b0, 8, "press6_released");
    check("stall_valid", int'(key_bus.key_valid), 1);
    check("stall_code", int'(key_bus.key_code), 5);
    check("overrun_pulses", ovr_cnt, 1);
    @(posedge clk_in);
    #1 key_bus.key_ready = 1'b1;
    @(posedge clk_in);
    #1;
    check("valid_drop_after_accept", int'(key_bus.key_valid), 0);

    // Reset in the middle of a debounce.
    row_force = 4'b0001;
    wait_ticks(2);
    rst = 1'b1;
    row_force = '0;
    @(posedge clk_in);
    #1;
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    wait_ticks(8);
    check("post_reset_no_held", int'(key_held), 0);
    check("post_reset_no_valid", int'(key_bus.key_valid), 0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: accept, then +8, +11, +14, +17 ticks; released before +20.
    evt_tick_q.delete();
    repeat (5) exp_q.push_back(11);
    pressed[11] = 1'b1;
    wait_held(1'b1, 12, "press11_held_rise");
    wait_ticks(19);
    pressed = '0;
    wait_held(1'b0, 8, "press11_released");
    check("repeat_event_count", evt_tick_q.size(), 5);
    if (evt_tick_q.size() == 5) begin
      check("repeat_first_gap", evt_tick_q[1] - evt_tick_q[0], 8);
      check("repeat_gap_2", evt_tick_q[2] - evt_tick_q[1], 3);
      check("repeat_gap_3", evt_tick_q[3] - evt_tick_q[2], 3);
      check("repeat_gap_4", evt_tick_q[4] - evt_tick_q[3], 3);
    end
`endif

    repeat (20) @(posedge clk_in);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4×4 matrix-keypad scanner and debouncer, directly downstream of the team clock divider. Its scan and debounce timing is paced by the divider's 5 ms tick pulse. It drives one keypad column low at a time, samples the synchronized rows, and debounces a press. Each press is delivered as a 4-bit key code over a valid/ready handshake to the project's input-handling logic.

## Interface
- DEBOUNCE_TICKS, 4: consecutive stable scan_tick samples required to accept a press and, separately, a release.
- REPEAT_DELAY_TICKS, 100: held ticks before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE_TICKS, 20: ticks between repeats after the first. Used only with KEYPAD_REPEAT_EN.
- clk_in  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- scan_tick  in  1  one-cycle pulse from the clock divider (5 ms); every high cycle counts as one tick
- row_in  in  4  keypad rows, active-low, pulled up externally, asynchronous to clk_in
- col_out  out  4  column drive, active-low, exactly one bit low at all times
- key_code  out  4  row*4 + col of the accepted key
- key_valid  out  1  key_code is valid; held until accepted
- key_ready  in  1  consumer accepts when key_valid && key_ready at a posedge
- key_held  out  1  high while a debounced key is down
- overrun  out  1  one-cycle pulse when a key event is dropped

## Operation
- row_in passes through a 2-flop synchronizer (reset value 4'b1111). The FSM uses only the synchronized rows (rs).
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE. All transitions occur only on cycles with scan_tick=1.
- SCAN:
  - If any rs bit is low, latch the current column and the lowest-index low row, set cnt=1, go to DEBOUNCE.
  - Otherwise advance the column 0→1→2→3→0. col_out for column c is ~(1<<c).
- DEBOUNCE: column frozen.
  - Latched row still low: cnt++. When cnt reaches DEBOUNCE_TICKS, emit the event and go to HELD.
  - Latched row high: go to SCAN and advance the column. No event.
- HELD: key_held=1.
  - Latched row high: cnt=1, go to RELEASE.
  - Latched row low: stay in HELD.
- RELEASE: key_held stays 1.
  - Latched row high: cnt++. When cnt reaches DEBOUNCE_TICKS, key_held=0, go to SCAN and advance the column.
  - Latched row low: go back to HELD.
- Emit rules:
  - key_valid=0, or accept in the same cycle: load key_code and set key_valid=1.
  - key_valid=1 and not accepted: drop the event, keep key_code, pulse overrun.
- Other keys pressed while in DEBOUNCE, HELD or RELEASE are ignored; only the latched row/column is tracked.
- Counters saturate. Width is $clog2 of the largest governing parameter, plus 1.

## Timing
- Reset values:
  - col_out=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0
  - state SCAN, cnt=0, column 0
- A row_in change is visible to the FSM 2 clk_in cycles later.
- key_valid and key_code update on the clk_in edge after the scan_tick cycle that completes debounce.
- key_valid deasserts on the edge after valid && ready, unless a new event loads in that same cycle.
- col_out changes on the edge after the advancing scan_tick. The row sample for that column is taken on the next scan_tick, giving one full tick of settling.
- Reset mid-operation: all state returns to reset values immediately. A pending key_valid is lost.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter counts scan_ticks; it clears on entry to HELD and after each repeat.
  - The first repeat event fires after REPEAT_DELAY_TICKS, then one every REPEAT_RATE_TICKS.
  - Repeats use the same emit rules, including overrun.
  - RELEASE freezes the repeat counter. Returning to HELD resumes it.
- Undefined: exactly one event per press. No repeat logic or counter is synthesized.

## Structure
- keypad_pkg holds:
  - state enum
  - ROWS=4, COLS=4 constants
  - key_code_t (4-bit)
  - COL_IDLE=4'b1110
- Sub-module sync2: parameterized-width 2-flop synchronizer with async reset and a reset value parameter, instantiated for row_in.
- All other logic lives in keypad_scan.

## Test plan
Bench setup: DEBOUNCE_TICKS=4, scan_tick every 10 cycles, key_ready=1 unless stated.
- Press row 2 at column 1, held for 6 ticks → key_code=9, one key_valid pulse. key_held rises with it and falls 4 ticks after release.
- Rows 0 and 3 both low at column 2 → key_code=2.
- Bounce: row 1 low for 2 ticks then high → no key_valid, column scan resumes (col_out cycles 1110→1101→…).
- key_ready=0; press and release code 5, then code 6 → key_code stays 5, key_valid stays 1, one overrun pulse. Raise key_ready → key_valid falls next cycle.
- Assert rst during DEBOUNCE → all outputs at reset values next cycle. No event after rst deasserts with the key released.
- KEYPAD_REPEAT_EN with REPEAT_DELAY_TICKS=8, REPEAT_RATE_TICKS=3, key held for 20 ticks after accept → events at accept, +8, +11, +14, +17.
